// File: rtl/hwpe_eai_pkg.sv
// Shared definitions for the EAI sequencer: FSM states, instruction record layout
// and error-flag bit positions.
package hwpe_eai_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StWaitRsp,
        StDone
    } state_e;

    localparam int unsigned XD_BIT    = 14;

    localparam int unsigned INSTR_MSB = 95;
    localparam int unsigned RS1_MSB   = 63;
    localparam int unsigned RS2_MSB   = 31;

    localparam int unsigned ERR_RSP   = 0;
    localparam int unsigned ERR_TAG   = 1;

endpackage

// File: rtl/hwpe_eai_sequencer.sv
// EAI initiator: fetches {instr, rs1, rs2} records from instruction SRAM, issues them one
// at a time and stores the response data of xd instructions into the result SRAM.
module hwpe_eai_sequencer
    import hwpe_eai_pkg::*;
#(
    parameter int unsigned IMEM_AW = 12,
    parameter int unsigned RMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               start,
    input  logic [IMEM_AW-1:0] instr_base,
    input  logic [15:0]        instr_len,
    input  logic [RMEM_AW-1:0] res_base,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic [15:0]        issued,

    output logic               imem_ren,
    output logic [IMEM_AW-1:0] imem_ra,
    input  logic [95:0]        imem_rd,

    output logic               eai_req_valid,
    input  logic               eai_req_ready,
    output logic [31:0]        eai_req_instr,
    output logic [31:0]        eai_req_rs1,
    output logic [31:0]        eai_req_rs2,
    output logic [1:0]         eai_req_itag,

    input  logic               eai_rsp_valid,
    output logic               eai_rsp_ready,
    input  logic [31:0]        eai_rsp_wdat,
    input  logic [1:0]         eai_rsp_itag,
    input  logic               eai_rsp_err,

    output logic               res_wen,
    output logic [RMEM_AW-1:0] res_wa,
    output logic [31:0]        res_wd
);

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] iptr_q, iptr_d;
    logic [RMEM_AW-1:0] rptr_q, rptr_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        issued_q, issued_d;
    logic [1:0]         tag_q, tag_d;
    logic [1:0]         err_q, err_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [1:0]         itag_q, itag_d;
    logic               xd_q, xd_d;
    logic               res_wen_q, res_wen_d;
    logic [RMEM_AW-1:0] res_wa_q, res_wa_d;
    logic [31:0]        res_wd_q, res_wd_d;

    logic [31:0]        rec_instr;

    assign rec_instr = imem_rd[INSTR_MSB -: 32];

    always_comb begin
        state_d   = state_q;
        iptr_d    = iptr_q;
        rptr_d    = rptr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        tag_d     = tag_q;
        err_d     = err_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        itag_d    = itag_q;
        xd_d      = xd_q;
        res_wen_d = 1'b0;
        res_wa_d  = res_wa_q;
        res_wd_d  = res_wd_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d    = '0;
                    issued_d = '0;
                    tag_d    = '0;
                    if (instr_len != 16'd0) begin
                        len_d   = instr_len;
                        rptr_d  = res_base;
                        iptr_d  = instr_base;
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFetch: begin
                iptr_d  = iptr_q + IMEM_AW'(1);
                state_d = StLoad;
            end
            StLoad: begin
                instr_d = rec_instr;
                rs1_d   = imem_rd[RS1_MSB -: 32];
                rs2_d   = imem_rd[RS2_MSB -: 32];
                itag_d  = tag_q;
                xd_d    = rec_instr[XD_BIT];
                state_d = StIssue;
            end
            StIssue: begin
                if (eai_req_ready) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (eai_rsp_valid) begin
                    // Errors are only recorded; the run always continues.
                    if (eai_rsp_err) begin
                        err_d[ERR_RSP] = 1'b1;
                    end
                    if (eai_rsp_itag != itag_q) begin
                        err_d[ERR_TAG] = 1'b1;
                    end
                    issued_d = issued_q + 16'd1;
                    tag_d    = tag_q + 2'd1;
                    if (xd_q) begin
                        res_wen_d = 1'b1;
                        res_wa_d  = rptr_q;
                        res_wd_d  = eai_rsp_wdat;
                        rptr_d    = rptr_q + RMEM_AW'(1);
                    end
                    state_d = (issued_q + 16'd1 == len_q) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            iptr_q    <= '0;
            rptr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            tag_q     <= '0;
            err_q     <= '0;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            itag_q    <= '0;
            xd_q      <= 1'b0;
            res_wen_q <= 1'b0;
            res_wa_q  <= '0;
            res_wd_q  <= '0;
        end else begin
            state_q   <= state_d;
            iptr_q    <= iptr_d;
            rptr_q    <= rptr_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            itag_q    <= itag_d;
            xd_q      <= xd_d;
            res_wen_q <= res_wen_d;
            res_wa_q  <= res_wa_d;
            res_wd_q  <= res_wd_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign err           = err_q;
    assign issued        = issued_q;
    assign imem_ren      = (state_q == StFetch);
    assign imem_ra       = iptr_q;
    assign eai_req_valid = (state_q == StIssue);
    assign eai_req_instr = instr_q;
    assign eai_req_rs1   = rs1_q;
    assign eai_req_rs2   = rs2_q;
    assign eai_req_itag  = itag_q;
    assign eai_rsp_ready = (state_q == StWaitRsp);
    assign res_wen       = res_wen_q;
    assign res_wa        = res_wa_q;
    assign res_wd        = res_wd_q;

endmodule

// File: tb/tb_hwpe_eai_sequencer.sv
// Directed bench for hwpe_eai_sequencer: SRAM model, EAI responder and per-feature tests.
module tb_hwpe_eai_sequencer;

    localparam int unsigned IAW = 12;
    localparam int unsigned RAW = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [IAW-1:0] instr_base = '0;
    logic [15:0]    instr_len = '0;
    logic [RAW-1:0] res_base = '0;
    logic           busy, done;
    logic [1:0]     err;
    logic [15:0]    issued;
    logic           imem_ren;
    logic [IAW-1:0] imem_ra;
    logic [95:0]    imem_rd = '0;
    logic           eai_req_valid;
    logic           eai_req_ready = 1'b1;
    logic [31:0]    eai_req_instr, eai_req_rs1, eai_req_rs2;
    logic [1:0]     eai_req_itag;
    logic           eai_rsp_valid = 1'b0;
    logic           eai_rsp_ready;
    logic [31:0]    eai_rsp_wdat = '0;
    logic [1:0]     eai_rsp_itag = '0;
    logic           eai_rsp_err = 1'b0;
    logic           res_wen;
    logic [RAW-1:0] res_wa;
    logic [31:0]    res_wd;

    hwpe_eai_sequencer #(.IMEM_AW(IAW), .RMEM_AW(RAW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_base(instr_base),
        .instr_len(instr_len), .res_base(res_base), .busy(busy), .done(done), .err(err),
        .issued(issued), .imem_ren(imem_ren), .imem_ra(imem_ra), .imem_rd(imem_rd),
        .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready),
        .eai_req_instr(eai_req_instr), .eai_req_rs1(eai_req_rs1), .eai_req_rs2(eai_req_rs2),
        .eai_req_itag(eai_req_itag), .eai_rsp_valid(eai_rsp_valid),
        .eai_rsp_ready(eai_rsp_ready), .eai_rsp_wdat(eai_rsp_wdat),
        .eai_rsp_itag(eai_rsp_itag), .eai_rsp_err(eai_rsp_err), .res_wen(res_wen),
        .res_wa(res_wa), .res_wd(res_wd)
    );

    always #5 clk = ~clk;

    logic [95:0] imem [0:4095];
    always @(posedge clk) if (imem_ren) imem_rd <= imem[imem_ra];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int start_cyc;

    int             wr_cyc[$], acc_cyc[$], ren_cyc[$], valid_cyc[$], done_cyc[$];
    logic [RAW-1:0] wr_addr[$];
    logic [31:0]    wr_data[$];
    logic [95:0]    hs_pay[$], stall_pay[$];
    logic [1:0]     hs_tag[$], stall_tag[$];
    logic [1:0]     done_err;
    int             busy_fall;
    bit             busy_prev = 1'b0, valid_prev = 1'b0, hs_pend = 1'b0;
    int             stall_left = 0;
    bit             rsp_enable = 1'b1;
    logic [31:0]    rsp_data [8];
    logic [1:0]     rsp_xor [8];
    logic           rsp_err_tab [8];

    // Monitor and EAI responder; everything observed on the falling edge.
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (res_wen) begin
                wr_addr.push_back(res_wa);
                wr_data.push_back(res_wd);
                wr_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                done_err = err;
            end
            if (imem_ren) ren_cyc.push_back(cyc);
            if (eai_req_valid && !valid_prev) valid_cyc.push_back(cyc);
            valid_prev = eai_req_valid;
            if (busy_prev && !busy) busy_fall = cyc;
            busy_prev = busy;

            eai_rsp_valid = 1'b0;
            eai_rsp_wdat  = '0;
            eai_rsp_itag  = '0;
            eai_rsp_err   = 1'b0;
            if (hs_pend) begin
                hs_pend = 1'b0;
                idx = hs_tag.size() - 1;
                eai_rsp_valid = 1'b1;
                eai_rsp_wdat  = rsp_data[idx % 8];
                eai_rsp_itag  = hs_tag[idx] ^ rsp_xor[idx % 8];
                eai_rsp_err   = rsp_err_tab[idx % 8];
                if (eai_rsp_ready) acc_cyc.push_back(cyc);
            end

            if (eai_req_valid && stall_left > 0) begin
                eai_req_ready = 1'b0;
                stall_left--;
                stall_pay.push_back({eai_req_instr, eai_req_rs1, eai_req_rs2});
                stall_tag.push_back(eai_req_itag);
            end else begin
                eai_req_ready = 1'b1;
                if (eai_req_valid) begin
                    hs_pay.push_back({eai_req_instr, eai_req_rs1, eai_req_rs2});
                    hs_tag.push_back(eai_req_itag);
                    if (rsp_enable) hs_pend = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin
            rsp_data[i]    = 32'hD000_0000 + 32'(i);
            rsp_xor[i]     = 2'b00;
            rsp_err_tab[i] = 1'b0;
        end
        stall_left = 0;
        rsp_enable = 1'b1;
    endtask

    task automatic launch(input logic [IAW-1:0] b, input logic [15:0] n,
                          input logic [RAW-1:0] rb);
        step();
        wr_cyc.delete(); acc_cyc.delete(); ren_cyc.delete(); valid_cyc.delete();
        done_cyc.delete(); wr_addr.delete(); wr_data.delete(); hs_pay.delete();
        stall_pay.delete(); hs_tag.delete(); stall_tag.delete();
        busy_fall = -1;
        done_err  = 2'bxx;
        instr_base = b;
        instr_len  = n;
        res_base   = rb;
        start      = 1'b1;
        start_cyc  = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (done_cyc.size() != 0) begin
                to = 1'b0;
                break;
            end
            step();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, err, issued, imem_ren, imem_ra, eai_req_valid, eai_req_instr,
             eai_req_rs1, eai_req_rs2, eai_req_itag, eai_rsp_ready, res_wen, res_wa,
             res_wd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%b err=%b ra=%h instr=%h",
                     busy, err, imem_ra, eai_req_instr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        clear_cfg();
        rsp_data[0] = 32'h11; rsp_data[1] = 32'h22; rsp_data[2] = 32'h33;
        launch(12'h020, 16'd3, 12'h010);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
        n_checks++;
        if (ren_cyc.size() == 0 || ren_cyc[0] !== start_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_ren_latency: got %0d expected %0d", ren_cyc[0], start_cyc + 1);
        end
        n_checks++;
        if (valid_cyc.size() == 0 || valid_cyc[0] !== start_cyc + 3) begin
            n_fail++;
            $display("FAIL basic_valid_latency: got %0d expected %0d", valid_cyc[0],
                     start_cyc + 3);
        end
        n_checks++;
        if (acc_cyc.size() != 3 || acc_cyc[0] !== start_cyc + 4) begin
            n_fail++;
            $display("FAIL basic_accepts: got %0d first at %0d expected 3 first at %0d",
                     acc_cyc.size(), acc_cyc[0], start_cyc + 4);
        end
        n_checks++;
        if (hs_pay.size() != 3 || wr_addr.size() != 3) begin
            n_fail++;
            $display("FAIL basic_counts: got hs=%0d wr=%0d expected 3 3", hs_pay.size(),
                     wr_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hs_pay[i] !== imem[12'h020 + i] || hs_tag[i] !== 2'(i)) begin
                n_fail++;
                $display("FAIL basic_req[%0d]: got %h tag %0d expected %h tag %0d", i,
                         hs_pay[i], hs_tag[i], imem[12'h020 + i], i);
            end
            n_checks++;
            if (wr_addr[i] !== RAW'(12'h010 + i) || wr_data[i] !== rsp_data[i]) begin
                n_fail++;
                $display("FAIL basic_wr[%0d]: got %h=%h expected %h=%h", i, wr_addr[i],
                         wr_data[i], 12'h010 + i, rsp_data[i]);
            end
            n_checks++;
            if (wr_cyc[i] !== acc_cyc[i] + 1) begin
                n_fail++;
                $display("FAIL basic_wr_cyc[%0d]: got %0d expected %0d", i, wr_cyc[i],
                         acc_cyc[i] + 1);
            end
        end
        n_checks++;
        if (ren_cyc[1] !== acc_cyc[0] + 1 || valid_cyc[1] !== acc_cyc[0] + 3) begin
            n_fail++;
            $display("FAIL basic_next_issue: got ren %0d valid %0d expected %0d %0d",
                     ren_cyc[1], valid_cyc[1], acc_cyc[0] + 1, acc_cyc[0] + 3);
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] !== acc_cyc[2] + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d",
                     done_cyc.size(), done_cyc[0], acc_cyc[2] + 1);
        end
        n_checks++;
        if (busy_fall !== done_cyc[0] + 1) begin
            n_fail++;
            $display("FAIL basic_busy_fall: got %0d expected %0d", busy_fall, done_cyc[0] + 1);
        end
        n_checks++;
        if (err !== 2'b00 || issued !== 16'd3) begin
            n_fail++;
            $display("FAIL basic_status: got err=%b issued=%0d expected 00 3", err, issued);
        end
    endtask

    task automatic test_stall();
        bit to;
        clear_cfg();
        stall_left = 7;
        launch(12'h060, 16'd1, 12'h000);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL stall_timeout: got no done expected done"); end
        n_checks++;
        if (stall_pay.size() != 7 || hs_pay.size() != 1 || valid_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL stall_counts: got stall=%0d hs=%0d rises=%0d expected 7 1 1",
                     stall_pay.size(), hs_pay.size(), valid_cyc.size());
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (stall_pay[i] !== imem[12'h060] || stall_tag[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_payload[%0d]: got %h tag %0d expected %h tag 0", i,
                         stall_pay[i], stall_tag[i], imem[12'h060]);
            end
        end
        n_checks++;
        if (hs_pay[0] !== imem[12'h060] || done_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL stall_handshake: got %h done=%0d expected %h done=1", hs_pay[0],
                     done_cyc.size(), imem[12'h060]);
        end
    endtask

    task automatic test_no_xd();
        bit to;
        clear_cfg();
        launch(12'h050, 16'd2, 12'h040);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL noxd_timeout: got no done expected done"); end
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 12'h040 || wr_data[0] !== rsp_data[1]) begin
            n_fail++;
            $display("FAIL noxd_writes: got %0d writes first %h=%h expected 1 040=%h",
                     wr_addr.size(), wr_addr[0], wr_data[0], rsp_data[1]);
        end
        n_checks++;
        if (issued !== 16'd2 || acc_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL noxd_issued: got %0d acc %0d expected 2 2", issued, acc_cyc.size());
        end
    endtask

    task automatic test_errors();
        bit to;
        clear_cfg();
        rsp_xor[0]     = 2'b10;
        rsp_err_tab[2] = 1'b1;
        launch(12'h070, 16'd3, 12'h100);
        wait_done(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL err_timeout: got no done expected done"); end
        n_checks++;
        if (done_err !== 2'b11) begin
            n_fail++;
            $display("FAIL err_at_done: got %b expected 11", done_err);
        end
        n_checks++;
        if (issued !== 16'd3 || wr_addr.size() != 3 || hs_pay.size() != 3) begin
            n_fail++;
            $display("FAIL err_completion: got issued=%0d wr=%0d hs=%0d expected 3 3 3",
                     issued, wr_addr.size(), hs_pay.size());
        end
        clear_cfg();
        launch(12'h070, 16'd1, 12'h100);
        n_checks++;
        if (err !== 2'b00) begin
            n_fail++;
            $display("FAIL err_cleared_on_start: got %b expected 00", err);
        end
        wait_done(to);
        n_checks++;
        if (to || err !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clean_run: got err=%b timeout=%0d expected 00 0", err, to);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        clear_cfg();
        launch(12'h020, 16'd0, 12'h010);
        wait_done(to);
        n_checks++;
        if (to || done_cyc[0] !== start_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_done: got %0d expected %0d", done_cyc[0], start_cyc + 1);
        end
        n_checks++;
        if (ren_cyc.size() != 0 || valid_cyc.size() != 0 || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL zero_activity: got ren=%0d valid=%0d wr=%0d expected 0 0 0",
                     ren_cyc.size(), valid_cyc.size(), wr_addr.size());
        end
        n_checks++;
        if (busy_fall !== start_cyc + 2) begin
            n_fail++;
            $display("FAIL zero_busy_fall: got %0d expected %0d", busy_fall, start_cyc + 2);
        end
    endtask

    task automatic test_itag_wrap();
        bit to;
        logic [1:0] exp_tag [5];
        exp_tag[0] = 2'd0; exp_tag[1] = 2'd1; exp_tag[2] = 2'd2;
        exp_tag[3] = 2'd3; exp_tag[4] = 2'd0;
        clear_cfg();
        launch(12'h080, 16'd5, 12'h200);
        wait_done(to);
        n_checks++;
        if (to || hs_tag.size() != 5 || issued !== 16'd5) begin
            n_fail++;
            $display("FAIL wrap_counts: got hs=%0d issued=%0d expected 5 5", hs_tag.size(),
                     issued);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (hs_tag[i] !== exp_tag[i]) begin
                n_fail++;
                $display("FAIL wrap_itag[%0d]: got %0d expected %0d", i, hs_tag[i], exp_tag[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        bit reached;
        clear_cfg();
        rsp_enable = 1'b0;
        launch(12'h090, 16'd3, 12'h020);
        reached = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (eai_rsp_ready) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!reached) begin n_fail++; $display("FAIL rst_reach_wait: got 0 expected 1"); end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({busy, done, err, issued, imem_ren, imem_ra, eai_req_valid, eai_req_instr,
             eai_req_rs1, eai_req_rs2, eai_req_itag, eai_rsp_ready, res_wen, res_wa,
             res_wd} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got busy=%b ra=%h instr=%h itag=%0d expected 0",
                     busy, imem_ra, eai_req_instr, eai_req_itag);
        end
        step();
        rst_n = 1'b1;
        rsp_enable = 1'b1;
        step();
        n_checks++;
        if (done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d pulses expected 0", done_cyc.size());
        end
        launch(12'h090, 16'd2, 12'h020);
        wait_done(to);
        n_checks++;
        if (to || hs_pay.size() != 2 || hs_pay[0] !== imem[12'h090] ||
            hs_pay[1] !== imem[12'h091]) begin
            n_fail++;
            $display("FAIL rst_rerun_req: got %h expected %h", hs_pay[0], imem[12'h090]);
        end
        n_checks++;
        if (hs_tag[0] !== 2'd0 || hs_tag[1] !== 2'd1 || wr_addr[0] !== 12'h020 ||
            wr_addr[1] !== 12'h021 || issued !== 16'd2) begin
            n_fail++;
            $display("FAIL rst_rerun_result: got tags %0d,%0d wa %h,%h issued %0d expected",
                     hs_tag[0], hs_tag[1], wr_addr[0], wr_addr[1], issued);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            imem[i] = {32'h5000_4000 | 32'(i), 32'h1000_0000 | 32'(i), 32'h2000_0000 | 32'(i)};
        end
        imem[12'h050] = {32'h5000_0050, 32'h1000_0050, 32'h2000_0050};
        clear_cfg();
        rst_n = 1'b0;
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_stall();
        test_no_xd();
        test_errors();
        test_zero_len();
        test_itag_wrap();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
